// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : memory-access stage of the RISC-V core (sits after execute).
//
// Takes the execute result plus load/store control, runs one data-bus
// transaction per memory instruction and hands back a registered register-file
// writeback. The pipeline is stalled through hold2ctrl while a transaction is
// outstanding.
//
// Parameters
//   TIMEOUT_CYCLES : cycles allowed in REQ+WAIT before the access is aborted
//                    (0 disables the watchdog). Must be < 2**CNT_W.
//   CNT_W          : watchdog counter width.
//
// Optional feature (compile-time macro MEM_MISALIGN_TRAP_EN)
//   defined   : misaligned half/word accesses issue no bus request and pulse
//               misalign_err one cycle after acceptance.
//   undefined : misalign_err is tied 0; surplus low address bits are ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            execute presents an instruction
//   ex_rd_addr/data/wen execute result (ex_rd_data is the address for mem ops)
//   mem_en, mem_we      memory op / store select
//   mem_size            00 byte, 01 half, 10/11 word
//   mem_unsigned        zero-extend loads
//   st_data             store source
//   dbus_req/we/addr/be/wdata  data-bus request (all registered)
//   dbus_gnt            request accepted
//   dbus_rvalid/rdata   read response
//   rd_addr/rd_data/rd_wen2reg registered writeback
//   hold2ctrl           stall request (state != IDLE)
//   bus_err             one-cycle pulse on watchdog abort
//   misalign_err        one-cycle pulse on trapped misaligned access
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Handshakes
//   Upstream: an instruction transfers on a cycle with in_valid=1 and
//   hold2ctrl=0; while hold2ctrl=1 upstream keeps in_valid and its payload
//   stable. Bus: the request transfers on a cycle with dbus_req=1 and
//   dbus_gnt=1; until then every dbus_* output stays stable. A load's data
//   transfers on the first cycle in WAIT with dbus_rvalid=1.
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  ex_rd_addr,
  input  logic [31:0] ex_rd_data,
  input  logic        ex_rd_wen,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] st_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_wen2reg,
  output logic        hold2ctrl,
  output logic        bus_err,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbus_req_q;
  logic              dbus_we_q;
  logic [31:0]       dbus_addr_q;
  logic [3:0]        dbus_be_q;
  logic [31:0]       dbus_wdata_q;
  logic [4:0]        rd_addr_q;
  logic [31:0]       rd_data_q;
  logic              rd_wen_q;
  logic              bus_err_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lane_q;

  // Lane steering for the instruction currently offered by execute.
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        trap;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = st_data;
    case (mem_size)
      2'b00: begin
        be_d    = 4'b0001 << ex_rd_data[1:0];
        wdata_d = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {ex_rd_data[1], 1'b0};
        wdata_d = {2{st_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = st_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_err_q;

  always_comb begin
    trap = 1'b0;
    case (mem_size)
      2'b00:   trap = 1'b0;
      2'b01:   trap = ex_rd_data[0];
      default: trap = |ex_rd_data[1:0];
    endcase
  end

  assign misalign_err = misalign_err_q;
`else
  assign trap         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Load data extraction from the captured lane/size/sign information.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = dbus_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      rd_wen_q     <= 1'b0;
      bus_err_q    <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`endif
    end else begin
      // Pulses and writeback enable default low every cycle.
      rd_wen_q  <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!mem_en) begin
              rd_addr_q <= ex_rd_addr;
              rd_data_q <= ex_rd_data;
              rd_wen_q  <= ex_rd_wen && (ex_rd_addr != 5'd0);
            end else if (trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
              misalign_err_q <= 1'b1;
`endif
            end else begin
              state_q      <= S_REQ;
              cnt_q        <= '0;
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= mem_we;
              dbus_addr_q  <= {ex_rd_data[31:2], 2'b00};
              dbus_be_q    <= be_d;
              dbus_wdata_q <= mem_we ? wdata_d : 32'd0;
              rd_addr_q    <= ex_rd_addr;
              size_q       <= mem_size;
              uns_q        <= mem_unsigned;
              lane_q       <= ex_rd_data[1:0];
            end
          end
        end

        S_REQ: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (dbus_gnt) begin
            dbus_req_q <= 1'b0;
            dbus_we_q  <= 1'b0;
            state_q    <= dbus_we_q ? S_IDLE : S_WAIT;
          end else if (WDOG_EN && (cnt_q >= CNT_LAST)) begin
            dbus_req_q <= 1'b0;
            dbus_we_q  <= 1'b0;
            bus_err_q  <= 1'b1;
            state_q    <= S_IDLE;
          end
        end

        S_WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (dbus_rvalid) begin
            rd_data_q <= ld_val;
            rd_wen_q  <= (rd_addr_q != 5'd0);
            state_q   <= S_IDLE;
          end else if (WDOG_EN && (cnt_q >= CNT_LAST)) begin
            // ">=" also covers a grant taken on the very last REQ cycle,
            // which enters WAIT with the budget already spent.
            bus_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_be    = dbus_be_q;
  assign dbus_wdata = dbus_wdata_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign rd_wen2reg = rd_wen_q;
  assign bus_err    = bus_err_q;
  assign hold2ctrl  = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rd_data;
  logic        ex_rd_wen;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] st_data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_wen2reg;
  logic        hold2ctrl;
  logic        bus_err;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data), .ex_rd_wen(ex_rd_wen),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .st_data(st_data),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen2reg(rd_wen2reg),
    .hold2ctrl(hold2ctrl), .bus_err(bus_err), .misalign_err(misalign_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle;
    in_valid = 1'b0; ex_rd_addr = '0; ex_rd_data = '0; ex_rd_wen = 1'b0;
    mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    st_data = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
  endtask

  task automatic drive_mem(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [31:0] st);
    in_valid = 1'b1; mem_en = 1'b1; mem_we = we; ex_rd_data = addr; mem_size = size;
    mem_unsigned = uns; ex_rd_addr = rd; ex_rd_wen = ~we; st_data = st;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    total++; if (dbus_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dbus_req); end
    total++; if (dbus_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", dbus_we); end
    total++; if (dbus_addr !== 32'd0 || dbus_be !== 4'd0 || dbus_wdata !== 32'd0) begin bad++; $display("FAIL reset_bus got=%h/%b/%h exp=0", dbus_addr, dbus_be, dbus_wdata); end
    total++; if (rd_addr !== 5'd0 || rd_data !== 32'd0 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL reset_wb got=%h/%h/%b exp=0", rd_addr, rd_data, rd_wen2reg); end
    total++; if (hold2ctrl !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", hold2ctrl, bus_err, misalign_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu(input logic [4:0] rd, input logic [31:0] d, input logic wen);
    logic exp_wen;
    exp_wen = wen && (rd != 5'd0);
    in_valid = 1'b1; mem_en = 1'b0; ex_rd_addr = rd; ex_rd_data = d; ex_rd_wen = wen;
    total++; if (hold2ctrl !== 1'b0) begin bad++; $display("FAIL alu_hold_pre got=%b exp=0", hold2ctrl); end
    tick();
    drive_idle();
    total++; if (rd_wen2reg !== exp_wen) begin bad++; $display("FAIL alu_wen rd=%0d got=%b exp=%b", rd, rd_wen2reg, exp_wen); end
    total++; if (rd_addr !== rd || rd_data !== d) begin bad++; $display("FAIL alu_wb got=%0d/%h exp=%0d/%h", rd_addr, rd_data, rd, d); end
    total++; if (hold2ctrl !== 1'b0 || dbus_req !== 1'b0) begin bad++; $display("FAIL alu_nostall got=%b/%b exp=0/0", hold2ctrl, dbus_req); end
    tick();
    total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL alu_wen_pulse got=%b exp=0", rd_wen2reg); end
  endtask

  // Load with grant on the first REQ cycle and rvalid on the first WAIT cycle.
  task automatic test_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_val, input logic [3:0] exp_be,
                           input logic [31:0] exp_addr);
    drive_mem(1'b0, addr, size, uns, rd, 32'd0);
    tick();
    drive_idle();
    total++; if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || hold2ctrl !== 1'b1) begin bad++; $display("FAIL %s_req got=req%b we%b hold%b exp=req1 we0 hold1", nm, dbus_req, dbus_we, hold2ctrl); end
    total++; if (dbus_addr !== exp_addr || dbus_be !== exp_be) begin bad++; $display("FAIL %s_addr got=%h/%b exp=%h/%b", nm, dbus_addr, dbus_be, exp_addr, exp_be); end
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    total++; if (dbus_req !== 1'b0 || hold2ctrl !== 1'b1 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_wait got=req%b hold%b wen%b exp=req0 hold1 wen0", nm, dbus_req, hold2ctrl, rd_wen2reg); end
    dbus_rvalid = 1'b1; dbus_rdata = rdata;
    tick();
    dbus_rvalid = 1'b0; dbus_rdata = 32'hxxxx_xxxx;
    total++; if (rd_data !== exp_val) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, rd_data, exp_val); end
    total++; if (rd_wen2reg !== (rd != 5'd0) || rd_addr !== rd || hold2ctrl !== 1'b0) begin bad++; $display("FAIL %s_wb got=wen%b rd%0d hold%b exp=wen%b rd%0d hold0", nm, rd_wen2reg, rd_addr, hold2ctrl, (rd != 5'd0), rd); end
    tick();
    total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_wen_pulse got=%b exp=0", nm, rd_wen2reg); end
  endtask

  // LB with two REQ cycles and two WAIT cycles: stall must last exactly 4 cycles.
  task automatic test_lb_delayed;
    int hold_cnt = 0;
    drive_mem(1'b0, 32'h0000_0103, 2'b00, 1'b0, 5'd7, 32'd0);
    tick();
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      if (hold2ctrl === 1'b1) hold_cnt++;
      total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL lbd_early_wen cyc=%0d got=%b exp=0", c, rd_wen2reg); end
      if (c < 2) begin
        total++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_be !== 4'b1000) begin bad++; $display("FAIL lbd_req cyc=%0d got=%b/%h/%b exp=1/00000100/1000", c, dbus_req, dbus_addr, dbus_be); end
      end else begin
        total++; if (dbus_req !== 1'b0) begin bad++; $display("FAIL lbd_wait_req cyc=%0d got=%b exp=0", c, dbus_req); end
      end
      dbus_gnt    = (c == 1);
      dbus_rvalid = (c == 3);
      dbus_rdata  = (c == 3) ? 32'h80FF_0000 : 32'd0;
      tick();
    end
    drive_idle();
    if (hold2ctrl === 1'b1) hold_cnt++;
    total++; if (hold_cnt != 4) begin bad++; $display("FAIL lbd_hold_cycles got=%0d exp=4", hold_cnt); end
    total++; if (rd_data !== 32'hFFFF_FF80 || rd_wen2reg !== 1'b1 || rd_addr !== 5'd7) begin bad++; $display("FAIL lbd_wb got=%h/%b/%0d exp=ffffff80/1/7", rd_data, rd_wen2reg, rd_addr); end
    tick();
  endtask

  // Store held in REQ for wait_cyc cycles before grant.
  task automatic test_store(input string nm, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] st, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                            input int wait_cyc);
    drive_mem(1'b1, addr, size, 1'b0, 5'd4, st);
    tick();
    drive_idle();
    for (int c = 0; c <= wait_cyc; c++) begin
      total++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || hold2ctrl !== 1'b1) begin bad++; $display("FAIL %s_req cyc=%0d got=req%b we%b hold%b exp=111", nm, c, dbus_req, dbus_we, hold2ctrl); end
      total++; if (dbus_be !== exp_be || dbus_wdata !== exp_wdata || dbus_addr !== exp_addr) begin bad++; $display("FAIL %s_lanes cyc=%0d got=%b/%h/%h exp=%b/%h/%h", nm, c, dbus_be, dbus_wdata, dbus_addr, exp_be, exp_wdata, exp_addr); end
      total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_wen cyc=%0d got=%b exp=0", nm, c, rd_wen2reg); end
      dbus_gnt = (c == wait_cyc);
      tick();
    end
    dbus_gnt = 1'b0;
    total++; if (hold2ctrl !== 1'b0 || dbus_req !== 1'b0 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_done got=hold%b req%b wen%b exp=000", nm, hold2ctrl, dbus_req, rd_wen2reg); end
    tick();
    total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_nowb got=%b exp=0", nm, rd_wen2reg); end
  endtask

  // TIMEOUT_CYCLES=4: abort after 4 busy cycles, from REQ or from WAIT.
  task automatic test_timeout(input string nm, input logic grant_first);
    int busy = 0;
    drive_mem(1'b0, 32'h0000_0300, 2'b10, 1'b0, 5'd6, 32'd0);
    tick();
    drive_idle();
    while (hold2ctrl === 1'b1 && busy < 10) begin
      total++; if (bus_err !== 1'b0 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL %s_busy cyc=%0d got=err%b wen%b exp=00", nm, busy, bus_err, rd_wen2reg); end
      dbus_gnt = grant_first && (busy == 0);
      busy++;
      tick();
    end
    dbus_gnt = 1'b0;
    total++; if (busy != 4) begin bad++; $display("FAIL %s_cycles got=%0d exp=4", nm, busy); end
    total++; if (bus_err !== 1'b1 || dbus_req !== 1'b0 || rd_wen2reg !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL %s_abort got=err%b req%b wen%b st%0d exp=err1 req0 wen0 st0", nm, bus_err, dbus_req, rd_wen2reg, dbg_state); end
    tick();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL %s_err_pulse got=%b exp=0", nm, bus_err); end
  endtask

  task automatic test_reset_mid;
    // Reset while in REQ: request must drop without waiting for a clock.
    drive_mem(1'b0, 32'h0000_0400, 2'b10, 1'b0, 5'd8, 32'd0);
    tick();
    drive_idle();
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL rst_req_state got=%0d exp=1", dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dbus_req !== 1'b0 || hold2ctrl !== 1'b0) begin bad++; $display("FAIL rst_in_req got=req%b hold%b exp=00", dbus_req, hold2ctrl); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    // Reset while in WAIT, then a late rvalid that must be ignored.
    drive_mem(1'b0, 32'h0000_0404, 2'b10, 1'b0, 5'd9, 32'd0);
    tick();
    drive_idle();
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    total++; if (dbg_state !== 2'd2 || hold2ctrl !== 1'b1) begin bad++; $display("FAIL rst_wait_state got=%0d/%b exp=2/1", dbg_state, hold2ctrl); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dbus_req !== 1'b0 || hold2ctrl !== 1'b0 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL rst_in_wait got=req%b hold%b wen%b exp=000", dbus_req, hold2ctrl, rd_wen2reg); end
    @(negedge clk) rst_n = 1'b1;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    tick();
    dbus_rvalid = 1'b0;
    total++; if (rd_wen2reg !== 1'b0 || rd_data !== 32'd0 || hold2ctrl !== 1'b0) begin bad++; $display("FAIL rst_late_rvalid got=wen%b data%h hold%b exp=0/0/0", rd_wen2reg, rd_data, hold2ctrl); end
    tick();
  endtask

  // ALU instruction held upstream while a load completes; taken on the IDLE return cycle.
  task automatic test_back_to_back;
    drive_mem(1'b0, 32'h0000_0500, 2'b10, 1'b0, 5'd3, 32'd0);
    tick();
    in_valid = 1'b1; mem_en = 1'b0; ex_rd_addr = 5'd9; ex_rd_data = 32'h55; ex_rd_wen = 1'b1;
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1357_9BDF;
    tick();
    dbus_rvalid = 1'b0;
    total++; if (rd_wen2reg !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h1357_9BDF) begin bad++; $display("FAIL b2b_load got=%b/%0d/%h exp=1/3/13579bdf", rd_wen2reg, rd_addr, rd_data); end
    total++; if (hold2ctrl !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b exp=0", hold2ctrl); end
    tick();
    drive_idle();
    total++; if (rd_wen2reg !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h55) begin bad++; $display("FAIL b2b_alu got=%b/%0d/%h exp=1/9/00000055", rd_wen2reg, rd_addr, rd_data); end
    tick();
    total++; if (rd_wen2reg !== 1'b0) begin bad++; $display("FAIL b2b_single got=%b exp=0", rd_wen2reg); end
  endtask

  task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
    drive_mem(1'b0, 32'h0000_0103, 2'b10, 1'b0, 5'd5, 32'd0);
    tick();
    drive_idle();
    total++; if (misalign_err !== 1'b1 || dbus_req !== 1'b0 || hold2ctrl !== 1'b0 || rd_wen2reg !== 1'b0) begin bad++; $display("FAIL mis_trap got=err%b req%b hold%b wen%b exp=1000", misalign_err, dbus_req, hold2ctrl, rd_wen2reg); end
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misalign_err); end
`else
    test_load("lw_mis", 32'h0000_0103, 2'b10, 1'b0, 5'd5, 32'h1122_3344, 32'h1122_3344, 4'b1111, 32'h100);
    test_load("lh_mis", 32'h0000_0101, 2'b01, 1'b0, 5'd5, 32'hABCD_1234, 32'h0000_1234, 4'b0011, 32'h100);
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_tied got=%b exp=0", misalign_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu(5'd5, 32'h0000_1234, 1'b1);
    test_alu(5'd0, 32'hDEAD_0000, 1'b1);
    test_alu(5'd12, 32'hFFFF_FFFF, 1'b0);
    test_lb_delayed();
    test_load("lhu", 32'h0000_0102, 2'b01, 1'b1, 5'd10, 32'h8001_1234, 32'h0000_8001, 4'b1100, 32'h100);
    test_load("lh",  32'h0000_0100, 2'b01, 1'b0, 5'd11, 32'h1234_8765, 32'hFFFF_8765, 4'b0011, 32'h100);
    test_load("lbu", 32'h0000_0101, 2'b00, 1'b1, 5'd12, 32'h0000_F300, 32'h0000_00F3, 4'b0010, 32'h100);
    test_load("lb2", 32'h0000_0102, 2'b00, 1'b0, 5'd13, 32'h007F_0000, 32'h0000_007F, 4'b0100, 32'h100);
    test_load("lw",  32'h0000_010C, 2'b10, 1'b0, 5'd14, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h10C);
    test_load("lw_x0", 32'h0000_0110, 2'b10, 1'b0, 5'd0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'b1111, 32'h110);
    test_store("sb",  32'h0000_0201, 2'b00, 32'hAABB_CCDD, 4'b0010, 32'hDDDD_DDDD, 32'h200, 1);
    test_store("sb3", 32'h0000_0203, 2'b00, 32'h0000_005A, 4'b1000, 32'h5A5A_5A5A, 32'h200, 0);
    test_store("sh",  32'h0000_0202, 2'b01, 32'h1122_3344, 4'b1100, 32'h3344_3344, 32'h200, 2);
    test_store("sw",  32'h0000_0208, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h208, 0);
    test_store("s11", 32'h0000_020C, 2'b11, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h20C, 0);
    test_timeout("to_req", 1'b0);
    test_timeout("to_wait", 1'b1);
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
